// File: rtl/olv_event_scheduler_pkg.sv
// Shared definitions for the output-layer control blocks: the scheduler
// state encoding and the layer geometry constants.
package olv_event_scheduler_pkg;

  localparam int P_S      = 42;  // synapses / event bitmap width
  localparam int P_N      = 8;   // neurons / spike vector width
  localparam int P_AW     = 6;   // AER address width, 2^P_AW > P_S
  localparam int P_CW     = 8;   // frame and error counter width
  localparam int P_SETTLE = 4;   // settle window after the fire cycle

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_FIRE,
    ST_SETTLE,
    ST_REPORT
  } state_e;

endpackage

// File: rtl/olv_event_scheduler_if.sv
// AER input beats and the winner result port between the scheduler
// (slave side) and its producer/consumer (master side).
interface olv_event_scheduler_if
  import olv_event_scheduler_pkg::*;
#(
  parameter int p_aw = P_AW,
  parameter int p_n  = P_N
);
  logic            i_aer_valid;
  logic [p_aw-1:0] i_aer_addr;
  logic            i_aer_last;
  logic            o_aer_ready;
  logic            o_win_valid;
  logic            o_win_hit;
  logic [p_n:1]    o_win_index;
  logic            i_win_ready;

  modport slave (
    input  i_aer_valid, i_aer_addr, i_aer_last, i_win_ready,
    output o_aer_ready, o_win_valid, o_win_hit, o_win_index
  );

  modport master (
    output i_aer_valid, i_aer_addr, i_aer_last, i_win_ready,
    input  o_aer_ready, o_win_valid, o_win_hit, o_win_index
  );
endinterface

// File: rtl/olv_event_scheduler_win_capture.sv
// Settle-window counter plus first-spike latch. start_i arms a window of
// p_settle cycles; the first nonzero spike inside the window is held until
// clear_i. done_o flags the last cycle of the window.
module olv_win_capture
#(
  parameter int p_n      = 8,
  parameter int p_settle = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [p_n:1] spike_i,
  input  logic         clear_i,
  output logic         done_o,
  output logic         hit_o,
  output logic [p_n:1] index_o
);
  localparam int CNT_W = (p_settle < 2) ? 1 : $clog2(p_settle + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic [p_n:1]     index_q, index_d;
  logic             active;

  // A nonzero count means the window is open (the SETTLE state).
  assign active  = (cnt_q != '0);
  assign done_o  = (cnt_q == CNT_W'(1));
  assign hit_o   = hit_q;
  assign index_o = index_q;

  // Window countdown and capture of the first spike only.
  always_comb begin
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    index_d = index_q;
    if (start_i) begin
      cnt_d   = CNT_W'(p_settle);
      hit_d   = 1'b0;
      index_d = '0;
    end else if (active) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (!hit_q && (spike_i != '0)) begin
        hit_d   = 1'b1;
        index_d = spike_i;
      end
    end
    if (clear_i) begin
      hit_d   = 1'b0;
      index_d = '0;
    end
  end

  // State register; reset discards any window in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      index_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      index_q <= index_d;
    end
  end
endmodule

// File: rtl/olv_event_scheduler.sv
// Time-step sequencer for the output layer: gathers AER beats into a synapse
// bitmap, fires it for one cycle, waits the settle window for the winner
// spike and presents the result on a valid/ready port.
module olv_event_scheduler
  import olv_event_scheduler_pkg::*;
#(
  parameter int p_s      = P_S,
  parameter int p_n      = P_N,
  parameter int p_aw     = P_AW,
  parameter int p_settle = P_SETTLE,
  parameter int p_cw     = P_CW
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  olv_event_scheduler_if.slave bus,
  output logic [p_s:1]         o_event,
  input  logic [p_n:1]         i_spike,
  output logic [p_cw-1:0]      o_frame_cnt,
  output logic [p_cw-1:0]      o_err_cnt,
  output logic                 o_busy
);
  localparam logic [p_aw-1:0] ADDR_MAX = p_aw'(p_s);

  state_e            state_q, state_d;
  logic [p_s:1]      bitmap_q, bitmap_d, bitmap_upd;
  logic [p_s:1]      event_q, event_d;
  logic [p_cw-1:0]   frame_q, frame_d;
  logic [p_cw-1:0]   err_q, err_d;
  logic              win_valid_q, win_valid_d;
  logic              aer_ready, accept, legal, handshake;
  logic              cap_start, cap_done, cap_hit;
  logic [p_n:1]      cap_index;

  function automatic logic [p_cw-1:0] sat_inc(input logic [p_cw-1:0] v);
    return (&v) ? v : v + p_cw'(1);
  endfunction

  // Addresses outside 1..p_s match no bit and leave the bitmap unchanged.
  function automatic logic [p_s:1] bitmap_set(input logic [p_s:1] bm,
                                              input logic [p_aw-1:0] addr);
    logic [p_s:1] r;
    r = bm;
    for (int i = 1; i <= p_s; i++) begin
      if (addr == p_aw'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Ready and busy come from the registered state only.
  assign aer_ready  = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  assign o_busy     = (state_q != ST_IDLE);
  assign accept     = bus.i_aer_valid && aer_ready;
  assign legal      = (bus.i_aer_addr != '0) && (bus.i_aer_addr <= ADDR_MAX);
  assign handshake  = (state_q == ST_REPORT) && bus.i_win_ready;
  assign cap_start  = (state_q == ST_FIRE);
  assign bitmap_upd = bitmap_set(bitmap_q, bus.i_aer_addr);

  assign bus.o_aer_ready = aer_ready;
  assign bus.o_win_valid = win_valid_q;
  assign bus.o_win_hit   = cap_hit;
  assign bus.o_win_index = cap_index;
  assign o_event         = event_q;
  assign o_frame_cnt     = frame_q;
  assign o_err_cnt       = err_q;

  olv_win_capture #(
    .p_n      (p_n),
    .p_settle (p_settle)
  ) u_win_capture (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .start_i (cap_start),
    .spike_i (i_spike),
    .clear_i (handshake),
    .done_o  (cap_done),
    .hit_o   (cap_hit),
    .index_o (cap_index)
  );

  // Next-state and datapath decode. The event register is loaded on the
  // edge that accepts the last beat so it is visible during FIRE.
  always_comb begin
    state_d     = state_q;
    bitmap_d    = bitmap_q;
    event_d     = '0;
    err_d       = err_q;
    frame_d     = frame_q;
    win_valid_d = win_valid_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (accept) begin
          if (!legal) err_d = sat_inc(err_q);
          if (bus.i_aer_last) begin
            event_d  = bitmap_upd;
            bitmap_d = '0;
            state_d  = ST_FIRE;
          end else begin
            bitmap_d = bitmap_upd;
            state_d  = ST_COLLECT;
          end
        end
      end
      ST_FIRE: state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (cap_done) begin
          win_valid_d = 1'b1;
          state_d     = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (bus.i_win_ready) begin
          win_valid_d = 1'b0;
          frame_d     = frame_q + p_cw'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any partial frame or result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      bitmap_q    <= '0;
      event_q     <= '0;
      err_q       <= '0;
      frame_q     <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitmap_q    <= bitmap_d;
      event_q     <= event_d;
      err_q       <= err_d;
      frame_q     <= frame_d;
      win_valid_q <= win_valid_d;
    end
  end
endmodule

// File: tb/tb_olv_event_scheduler.sv
// Scoreboard bench for olv_event_scheduler: expected events and results are
// queued as beats are driven and compared when the DUT presents them.
module tb_olv_event_scheduler;
  import olv_event_scheduler_pkg::*;

  localparam int S   = P_S;
  localparam int N   = P_N;
  localparam int AW  = P_AW;
  localparam int CW  = P_CW;
  localparam int SET = P_SETTLE;

  typedef struct packed {
    logic          hit;
    logic [N:1]    index;
    logic [CW-1:0] frame;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [S:1]    ev;
  logic [N:1]    spike;
  logic [CW-1:0] frame_cnt, err_cnt;
  logic          busy;

  olv_event_scheduler_if #(.p_aw(AW), .p_n(N)) sif ();

  olv_event_scheduler dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (sif),
    .o_event     (ev),
    .i_spike     (spike),
    .o_frame_cnt (frame_cnt),
    .o_err_cnt   (err_cnt),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [S:1]    exp_bm;
  logic [CW-1:0] exp_err, exp_frame;
  logic [S:1]    ev_q[$];
  res_t          res_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [AW-1:0] addr, input logic last);
    int g = 0;
    sif.i_aer_valid = 1'b1;
    sif.i_aer_addr  = addr;
    sif.i_aer_last  = last;
    while (!sif.o_aer_ready && g < 100) begin
      tick();
      g++;
    end
    checks++;
    if (sif.o_aer_ready !== 1'b1) begin
      errors++;
      $display("FAIL beat_accept: o_aer_ready=%b required 1 (addr %0d)", sif.o_aer_ready, addr);
    end
    if (addr != 0 && addr <= S) exp_bm[addr] = 1'b1;
    else if (exp_err != '1) exp_err = exp_err + 1'b1;
    if (last) begin
      ev_q.push_back(exp_bm);
      exp_bm = '0;
    end
    tick();
    sif.i_aer_valid = 1'b0;
    sif.i_aer_last  = 1'b0;
    sif.i_aer_addr  = '0;
  endtask

  task automatic check_event();
    logic [S:1] e;
    checks++;
    if (ev_q.size() == 0) begin
      errors++;
      $display("FAIL event_queue: no expected event, o_event=%h", ev);
    end else begin
      e = ev_q.pop_front();
      if (ev !== e) begin
        errors++;
        $display("FAIL event: o_event=%h required %h", ev, e);
      end
    end
  endtask

  task automatic push_result(input logic hit, input logic [N:1] index);
    res_t r;
    exp_frame = exp_frame + 1'b1;
    r.hit   = hit;
    r.index = index;
    r.frame = exp_frame;
    res_q.push_back(r);
  endtask

  task automatic expect_result(input int max_wait);
    res_t r;
    int g = 0;
    while (!sif.o_win_valid && g < max_wait) begin
      tick();
      g++;
    end
    checks++;
    if (sif.o_win_valid !== 1'b1) begin
      errors++;
      $display("FAIL win_valid_timeout: o_win_valid=%b required 1", sif.o_win_valid);
    end
    if (res_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL result_queue: empty, o_win_index=%h", sif.o_win_index);
      r = '0;
    end else begin
      r = res_q.pop_front();
    end
    checks++;
    if (sif.o_win_hit !== r.hit) begin
      errors++;
      $display("FAIL win_hit: got %b required %b", sif.o_win_hit, r.hit);
    end
    checks++;
    if (sif.o_win_index !== r.index) begin
      errors++;
      $display("FAIL win_index: got %h required %h", sif.o_win_index, r.index);
    end
    sif.i_win_ready = 1'b1;
    tick();
    sif.i_win_ready = 1'b0;
    checks++;
    if (sif.o_win_valid !== 1'b0 || sif.o_win_hit !== 1'b0 || sif.o_win_index !== '0) begin
      errors++;
      $display("FAIL win_clear: valid=%b hit=%b index=%h required 0 0 0",
               sif.o_win_valid, sif.o_win_hit, sif.o_win_index);
    end
    checks++;
    if (frame_cnt !== r.frame) begin
      errors++;
      $display("FAIL frame_cnt: got %0d required %0d", frame_cnt, r.frame);
    end
  endtask

  task automatic model_reset();
    exp_bm    = '0;
    exp_err   = '0;
    exp_frame = '0;
    ev_q.delete();
    res_q.delete();
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if (ev !== '0 || sif.o_win_valid !== 1'b0 || sif.o_win_hit !== 1'b0 ||
        sif.o_win_index !== '0 || frame_cnt !== '0 || err_cnt !== '0) begin
      errors++;
      $display("FAIL %s_outputs: ev=%h valid=%b hit=%b idx=%h frame=%0d err=%0d required all 0",
               name, ev, sif.o_win_valid, sif.o_win_hit, sif.o_win_index, frame_cnt, err_cnt);
    end
    checks++;
    if (sif.o_aer_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_state: ready=%b busy=%b required 1 0", name, sif.o_aer_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    model_reset();
    check_idle_zero("reset");
  endtask

  task automatic test_single_event();
    send_beat(6'd3, 1'b0);
    send_beat(6'd17, 1'b0);
    send_beat(6'd42, 1'b1);
    checks++;
    if (ev !== ((S'(1) << 2) | (S'(1) << 16) | (S'(1) << 41))) begin
      errors++;
      $display("FAIL single_event_bits: o_event=%h", ev);
    end
    check_event();
    push_result(1'b1, 8'h04);
    tick();
    checks++;
    if (ev !== '0) begin
      errors++;
      $display("FAIL event_one_cycle: o_event=%h required 0", ev);
    end
    spike = 8'h04;
    tick();
    spike = '0;
    expect_result(SET + 5);
  endtask

  task automatic test_no_winner();
    send_beat(6'd5, 1'b1);
    check_event();
    push_result(1'b0, '0);
    repeat (SET) tick();
    checks++;
    if (sif.o_win_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_early: valid=%b busy=%b required 0 1", sif.o_win_valid, busy);
    end
    tick();
    checks++;
    if (sif.o_win_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_exact: o_win_valid=%b required 1", sif.o_win_valid);
    end
    expect_result(0);
  endtask

  task automatic test_illegal();
    send_beat(6'd0, 1'b0);
    send_beat(6'd43, 1'b0);
    send_beat(6'd63, 1'b0);
    send_beat(6'd7, 1'b0);
    send_beat(6'd7, 1'b1);
    check_event();
    checks++;
    if (err_cnt !== exp_err || err_cnt !== 8'd3) begin
      errors++;
      $display("FAIL err_cnt: got %0d required 3 (model %0d)", err_cnt, exp_err);
    end
    push_result(1'b0, '0);
    expect_result(SET + 5);
    for (int i = 0; i < 255; i++) send_beat(6'd0, 1'b0);
    send_beat(6'd63, 1'b1);
    check_event();
    checks++;
    if (err_cnt !== 8'hFF || exp_err !== 8'hFF) begin
      errors++;
      $display("FAIL err_saturate: got %0d required 255", err_cnt);
    end
    push_result(1'b0, '0);
    expect_result(SET + 5);
  endtask

  task automatic test_back_pressure();
    res_t r;
    int g = 0;
    send_beat(6'd9, 1'b1);
    check_event();
    push_result(1'b1, 8'h10);
    tick();
    spike = 8'h10;
    tick();
    spike = '0;
    while (!sif.o_win_valid && g < SET + 5) begin
      tick();
      g++;
    end
    r = res_q.pop_front();
    sif.i_aer_valid = 1'b1;
    sif.i_aer_addr  = 6'd11;
    sif.i_aer_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (sif.o_win_valid !== 1'b1 || sif.o_win_hit !== r.hit ||
          sif.o_win_index !== r.index || sif.o_aer_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: valid=%b hit=%b idx=%h ready=%b required 1 %b %h 0",
                 sif.o_win_valid, sif.o_win_hit, sif.o_win_index, sif.o_aer_ready, r.hit, r.index);
      end
    end
    sif.i_win_ready = 1'b1;
    tick();
    sif.i_win_ready = 1'b0;
    checks++;
    if (sif.o_win_valid !== 1'b0 || frame_cnt !== r.frame || sif.o_aer_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b frame=%0d ready=%b required 0 %0d 1",
               sif.o_win_valid, frame_cnt, sif.o_aer_ready, r.frame);
    end
    exp_bm[11] = 1'b1;
    ev_q.push_back(exp_bm);
    exp_bm = '0;
    tick();
    sif.i_aer_valid = 1'b0;
    sif.i_aer_last  = 1'b0;
    check_event();
    push_result(1'b0, '0);
    expect_result(SET + 5);
  endtask

  task automatic test_spike_order();
    spike = 8'h40;
    send_beat(6'd2, 1'b0);
    spike = '0;
    send_beat(6'd4, 1'b1);
    check_event();
    push_result(1'b1, 8'h01);
    spike = 8'h20;
    tick();
    spike = 8'h01;
    tick();
    spike = 8'h80;
    tick();
    spike = '0;
    expect_result(SET + 5);
  endtask

  task automatic test_multi_spike();
    send_beat(6'd1, 1'b1);
    check_event();
    push_result(1'b1, 8'h81);
    tick();
    tick();
    spike = 8'h81;
    tick();
    spike = '0;
    expect_result(SET + 5);
  endtask

  task automatic test_mid_reset();
    send_beat(6'd6, 1'b1);
    check_event();
    tick();
    spike = 8'h02;
    tick();
    spike = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_idle_zero("mid_reset");
    for (int i = 0; i < SET + 2; i++) begin
      tick();
      checks++;
      if (sif.o_win_valid !== 1'b0 || ev !== '0) begin
        errors++;
        $display("FAIL mid_reset_leak: valid=%b ev=%h required 0 0", sif.o_win_valid, ev);
      end
    end
    send_beat(6'd1, 1'b1);
    check_event();
    push_result(1'b0, '0);
    expect_result(SET + 5);
  endtask

  initial begin
    rst             = 1'b1;
    spike           = '0;
    sif.i_aer_valid = 1'b0;
    sif.i_aer_addr  = '0;
    sif.i_aer_last  = 1'b0;
    sif.i_win_ready = 1'b0;
    model_reset();
    test_reset();
    test_single_event();
    test_no_winner();
    test_illegal();
    test_back_pressure();
    test_spike_order();
    test_multi_spike();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
